// File: rtl/mem_ram_bist.sv
// 1R1W synchronous RAM with configurable read latency and a built-in March
// (w0, r0w1, r1w0, r0) self-test engine that compares at the read pipeline output.
module mem_ram_bist #(
   parameter int unsigned WIDTH  = 73,
   parameter int unsigned AW     = 2,
   parameter int unsigned RD_LAT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ram_wr_en,
   input  logic [AW-1:0]    ram_wr_addr,
   input  logic [WIDTH-1:0] ram_wr_data,
   input  logic             ram_rd_en,
   input  logic [AW-1:0]    ram_rd_addr,
   output logic [WIDTH-1:0] ram_rd_data,
   output logic             ram_rd_valid,
   input  logic             bist_start,
   output logic             bist_busy,
   output logic             bist_done,
   output logic             bist_fail,
   output logic [AW-1:0]    bist_fail_addr,
   input  logic             tst_err_inj
);
   localparam int unsigned   DEPTH    = 2 ** AW;
   localparam int unsigned   LAST     = RD_LAT - 1;
   localparam logic [AW-1:0] ADDR_MAX = AW'(DEPTH - 1);

   typedef enum logic [2:0] {StIdle, StW0, StR0W1, StR1W0, StR0, StDrain, StDone} state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          drain_q, drain_d;

   logic             mem_we, mem_re, rd_exp;
   logic [AW-1:0]    mem_waddr, mem_raddr;
   logic [WIDTH-1:0] mem_wdata;
   logic             start_acc, bist_fin, busy;

   logic [WIDTH-1:0] mem [DEPTH];

   logic [WIDTH-1:0] p_data_q [RD_LAT];
   logic [AW-1:0]    p_addr_q [RD_LAT];
   logic [RD_LAT-1:0] p_valid_q, p_bist_q, p_exp_q;

   logic [WIDTH-1:0] rd_data_q;
   logic             rd_valid_q, done_q, fail_q, last_miscmp;
   logic [AW-1:0]    fail_addr_q;

   assign busy = (state_q != StIdle) && (state_q != StDone);

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      drain_d   = drain_q;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      mem_waddr = addr_q;
      mem_raddr = addr_q;
      mem_wdata = '0;
      rd_exp    = 1'b0;
      start_acc = 1'b0;
      bist_fin  = 1'b0;
      case (state_q)
         StIdle, StDone: begin
            mem_we    = ram_wr_en;
            mem_waddr = ram_wr_addr;
            mem_wdata = ram_wr_data;
            mem_re    = ram_rd_en;
            mem_raddr = ram_rd_addr;
            if (bist_start) begin
               start_acc = 1'b1;
               state_d   = StW0;
               addr_d    = '0;
            end
         end
         StW0: begin
            mem_we = 1'b1;
            addr_d = addr_q + 1'b1;
            if (addr_q == ADDR_MAX) state_d = StR0W1;
         end
         StR0W1: begin
            mem_re    = 1'b1;
            mem_we    = 1'b1;
            mem_wdata = '1;
            addr_d    = addr_q + 1'b1;
            if (addr_q == ADDR_MAX) begin
               state_d = StR1W0;
               addr_d  = ADDR_MAX;
            end
         end
         StR1W0: begin
            mem_re = 1'b1;
            mem_we = 1'b1;
            rd_exp = 1'b1;
            addr_d = addr_q - 1'b1;
            if (addr_q == '0) begin
               state_d = StR0;
               addr_d  = '0;
            end
         end
         StR0: begin
            mem_re = 1'b1;
            addr_d = addr_q + 1'b1;
            if (addr_q == ADDR_MAX) state_d = StDrain;
         end
         StDrain: begin
            drain_d = drain_q + 1'b1;
            if (drain_q == 1'(LAST)) begin
               state_d  = StDone;
               drain_d  = 1'b0;
               bist_fin = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         addr_q  <= '0;
         drain_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         drain_q <= drain_d;
      end
   end

   // Array deliberately has no reset.
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   // Stage 0 samples the array (read-before-write); later stages just delay.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(RD_LAT); i++) begin
            p_data_q[i] <= '0;
            p_addr_q[i] <= '0;
         end
         p_valid_q <= '0;
         p_bist_q  <= '0;
         p_exp_q   <= '0;
      end else begin
         p_data_q[0]  <= mem[mem_raddr] ^ {{(WIDTH - 1){1'b0}}, tst_err_inj};
         p_addr_q[0]  <= mem_raddr;
         p_valid_q[0] <= mem_re;
         p_bist_q[0]  <= busy;
         p_exp_q[0]   <= rd_exp;
         for (int i = 1; i < int'(RD_LAT); i++) begin
            p_data_q[i]  <= p_data_q[i-1];
            p_addr_q[i]  <= p_addr_q[i-1];
            p_valid_q[i] <= p_valid_q[i-1];
            p_bist_q[i]  <= p_bist_q[i-1];
            p_exp_q[i]   <= p_exp_q[i-1];
         end
      end
   end

   assign last_miscmp = p_valid_q[LAST] & p_bist_q[LAST] &
                        (p_data_q[LAST] != {WIDTH{p_exp_q[LAST]}});

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         done_q      <= 1'b0;
         fail_q      <= 1'b0;
         fail_addr_q <= '0;
      end else begin
         rd_valid_q <= p_valid_q[LAST] & ~p_bist_q[LAST];
         if (p_valid_q[LAST] & ~p_bist_q[LAST]) rd_data_q <= p_data_q[LAST];
         if (start_acc) begin
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
         end else begin
            if (bist_fin) done_q <= 1'b1;
            // Only the first miscompare of a run is recorded.
            if (last_miscmp && !fail_q) begin
               fail_q      <= 1'b1;
               fail_addr_q <= p_addr_q[LAST];
            end
         end
      end
   end

   assign ram_rd_data    = rd_data_q;
   assign ram_rd_valid   = rd_valid_q;
   assign bist_busy      = busy;
   assign bist_done      = done_q;
   assign bist_fail      = fail_q;
   assign bist_fail_addr = fail_addr_q;

endmodule
